// File: rtl/data_mem_ctrl_if.sv
// Two requester ports plus the word-wide data_mem side of data_mem_ctrl.
// Signal directions in the names are as seen from the controller.
interface data_mem_ctrl_if;
  logic        req0_i, we0_i, unsigned0_i;
  logic [1:0]  size0_i;
  logic [31:0] addr0_i, wdata0_i;
  logic        gnt0_o, rvalid0_o;

  logic        req1_i, we1_i, unsigned1_i;
  logic [1:0]  size1_i;
  logic [31:0] addr1_i, wdata1_i;
  logic        gnt1_o, rvalid1_o;

  logic [31:0] rdata_o;
  logic        err_o;

  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i;

  modport slave (
    input  req0_i, we0_i, unsigned0_i, size0_i, addr0_i, wdata0_i,
    input  req1_i, we1_i, unsigned1_i, size1_i, addr1_i, wdata1_i,
    output gnt0_o, rvalid0_o, gnt1_o, rvalid1_o, rdata_o, err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i
  );

  modport master (
    output req0_i, we0_i, unsigned0_i, size0_i, addr0_i, wdata0_i,
    output req1_i, we1_i, unsigned1_i, size1_i, addr1_i, wdata1_i,
    input  gnt0_o, rvalid0_o, gnt1_o, rvalid1_o, rdata_o, err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wd_o,
    output mem_rd_i
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Round-robin two-port byte/half/word front end for data_mem; rvalid at grant+3 (load, sub-word store), +2 (word store), +1 (error).
// Requesters hold req until gnt; no grant is issued while a transaction is in flight.
module data_mem_ctrl #(
  parameter int MEM_BYTES = 4096
) (
  input  logic           clk_i,
  input  logic           rst_i,
  data_mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, LDCAP, WR, RMW_RD, RMW_WR, RESP} state_e;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_e      state_q, state_d;
  logic        last_q, last_d, port_q, port_d;
  logic        we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

  logic        any_req, sel, sel_we, sel_uns, sel_err, gnt0, gnt1, rvalid;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{b[7] & ~uns}}, b};
      2'b01:   res = {{16{h[15] & ~uns}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) begin
      case (off)
        2'd0:    res[7:0]   = wd[7:0];
        2'd1:    res[15:8]  = wd[7:0];
        2'd2:    res[23:16] = wd[7:0];
        default: res[31:24] = wd[7:0];
      endcase
    end else if (off[1]) begin
      res[31:16] = wd[15:0];
    end else begin
      res[15:0] = wd[15:0];
    end
    return res;
  endfunction

  // On a tie the port that was not granted last wins; a lone requester always wins.
  assign any_req   = bus.req0_i | bus.req1_i;
  assign sel       = (bus.req0_i & bus.req1_i) ? ~last_q : bus.req1_i;
  assign sel_we    = sel ? bus.we1_i       : bus.we0_i;
  assign sel_uns   = sel ? bus.unsigned1_i : bus.unsigned0_i;
  assign sel_size  = sel ? bus.size1_i     : bus.size0_i;
  assign sel_addr  = sel ? bus.addr1_i     : bus.addr0_i;
  assign sel_wdata = sel ? bus.wdata1_i    : bus.wdata0_i;
  assign sel_err   = (sel_size == 2'b11)
                   | ((sel_size == 2'b01) & sel_addr[0])
                   | ((sel_size == 2'b10) & (sel_addr[1:0] != 2'b00))
                   | (sel_addr >= MEM_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt0    = ~sel;
          gnt1    = sel;
          last_d  = sel;
          port_d  = sel;
          we_d    = sel_we;
          uns_d   = sel_uns;
          size_d  = sel_size;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          rdata_d = '0;
          err_d   = sel_err;
          if (sel_err)                state_d = RESP;
          else if (!sel_we)           state_d = RD;
          else if (sel_size == 2'b10) state_d = WR;
          else                        state_d = RMW_RD;
        end
      end
      RD:     state_d = LDCAP;
      LDCAP: begin
        rdata_d = load_ext(bus.mem_rd_i, size_q, addr_q[1:0], uns_q);
        state_d = RESP;
      end
      WR:     state_d = RESP;
      RMW_RD: state_d = RMW_WR;
      RMW_WR: state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rvalid        = (state_q == RESP) & ~rst_i;
  assign bus.gnt0_o    = gnt0 & ~rst_i;
  assign bus.gnt1_o    = gnt1 & ~rst_i;
  assign bus.rvalid0_o = rvalid & ~port_q;
  assign bus.rvalid1_o = rvalid & port_q;
  assign bus.rdata_o   = rvalid ? rdata_q : 32'd0;
  assign bus.err_o     = rvalid & err_q;

  // Nothing reaches data_mem in a reset cycle, so an interrupted RMW never writes.
  assign bus.mem_req_o  = ((state_q == RD) | (state_q == WR) | (state_q == RMW_RD) |
                           (state_q == RMW_WR)) & ~rst_i;
  assign bus.mem_we_o   = ((state_q == WR) | (state_q == RMW_WR)) & ~rst_i;
  assign bus.mem_addr_o = {addr_q[31:2], 2'b00};
  assign bus.mem_wd_o   = (state_q == WR)     ? wdata_q :
                          (state_q == RMW_WR) ? merge_lane(bus.mem_rd_i, wdata_q, size_q, addr_q[1:0]) :
                                                32'd0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with a behavioural data_mem and a shadow-memory reference.
`timescale 1ns/1ps
module tb_data_mem_ctrl;
  localparam int MEM_BYTES = 4096;
  localparam int WORDS     = MEM_BYTES / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_ctrl_if bus();
  data_mem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  logic [31:0] dmem [WORDS];
  logic [31:0] smem [WORDS];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clk) begin
    if (pl_en) dmem[pl_idx] <= pl_val;
    else if (bus.mem_req_o) begin
      if (bus.mem_we_o) dmem[bus.mem_addr_o[11:2]] <= bus.mem_wd_o;
      else              bus.mem_rd_i <= dmem[bus.mem_addr_o[11:2]];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   gnt_log[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, gcyc0 = 0, gcyc1 = 0;
  int   nmemreq = 0, nmemwe = 0, nrvalid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req_o === 1'b1) nmemreq++;
      if (bus.mem_req_o === 1'b1 && bus.mem_we_o === 1'b1) nmemwe++;
      if (bus.gnt0_o === 1'b1) begin chk("gnt0_has_req", bus.req0_i, 1); gcyc0 = cyc; gnt_log.push_back(0); end
      if (bus.gnt1_o === 1'b1) begin chk("gnt1_has_req", bus.req1_i, 1); gcyc1 = cyc; gnt_log.push_back(1); end
      if (bus.rvalid0_o === 1'b1) begin
        nrvalid++;
        chk("rvalid0_expected", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk({e.tag, "_rdata"}, bus.rdata_o, e.rdata);
          chk({e.tag, "_err"}, bus.err_o, e.err);
          chk({e.tag, "_lat"}, cyc - gcyc0, e.lat);
        end
      end
      if (bus.rvalid1_o === 1'b1) begin
        nrvalid++;
        chk("rvalid1_expected", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk({e.tag, "_rdata"}, bus.rdata_o, e.rdata);
          chk({e.tag, "_err"}, bus.err_o, e.err);
          chk({e.tag, "_lat"}, cyc - gcyc1, e.lat);
        end
      end
    end
  end

  // Reference: shadow memory updated in issue order; expected data built with shifts and masks.
  task automatic predict(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a,
                         input logic [31:0] wd, input string tag, output exp_t e);
    logic [31:0] w, mask, lane;
    int sh;
    e.tag = tag; e.rdata = 32'd0; e.err = 1'b0; e.lat = 1;
    if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || a >= MEM_BYTES) begin
      e.err = 1'b1;
      return;
    end
    w    = smem[a[11:2]];
    sh   = (sz == 2'b00) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (!we) begin
      e.lat = 3;
      lane  = (w >> sh) & mask;
      if (!un && sz == 2'b00 && lane[7])  lane = lane | 32'hFFFF_FF00;
      if (!un && sz == 2'b01 && lane[15]) lane = lane | 32'hFFFF_0000;
      e.rdata = lane;
    end else begin
      e.lat = (sz == 2'b10) ? 2 : 3;
      smem[a[11:2]] = (w & ~(mask << sh)) | ((wd & mask) << sh);
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
    exp_t e;
    logic got;
    predict(we, sz, un, a, wd, tag, e);
    if (p == 0) begin
      q0.push_back(e);
      bus.we0_i = we; bus.size0_i = sz; bus.unsigned0_i = un; bus.addr0_i = a; bus.wdata0_i = wd;
      bus.req0_i = 1'b1;
    end else begin
      q1.push_back(e);
      bus.we1_i = we; bus.size1_i = sz; bus.unsigned1_i = un; bus.addr1_i = a; bus.wdata1_i = wd;
      bus.req1_i = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? bus.gnt0_o : bus.gnt1_o;
    end
    chk({tag, "_granted"}, got, 1);
    @(posedge clk); #1;
    if (p == 0) bus.req0_i = 1'b0; else bus.req1_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
    chk("drain_pending", q0.size() + q1.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = a[11:2]; pl_val = v;
    smem[a[11:2]] = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mr0, mw0, rv0;
    rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    bus.req0_i = 0; bus.we0_i = 0; bus.size0_i = 0; bus.unsigned0_i = 0; bus.addr0_i = 0; bus.wdata0_i = 0;
    bus.req1_i = 0; bus.we1_i = 0; bus.size1_i = 0; bus.unsigned1_i = 0; bus.addr1_i = 0; bus.wdata1_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt0", bus.gnt0_o, 0);       chk("rst_gnt1", bus.gnt1_o, 0);
    chk("rst_rvalid0", bus.rvalid0_o, 0); chk("rst_rvalid1", bus.rvalid1_o, 0);
    chk("rst_err", bus.err_o, 0);         chk("rst_rdata", bus.rdata_o, 0);
    chk("rst_mem_req", bus.mem_req_o, 0); chk("rst_mem_we", bus.mem_we_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0); chk("rst_mem_wd", bus.mem_wd_o, 0);
    @(posedge clk); #1;

    issue(0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, "st_w100"); drain();
    issue(0, 0, 2'b10, 0, 32'h100, 32'h0, "ld_w100");        drain();

    preload(32'h200, 32'h11223344);
    issue(0, 1, 2'b00, 0, 32'h201, 32'h000000AA, "st_b201"); drain();
    chk("mem_b201", dmem[32'h200 >> 2], 32'h1122AA44);
    issue(0, 0, 2'b00, 0, 32'h201, 32'h0, "ld_b201_s");
    issue(0, 0, 2'b00, 1, 32'h201, 32'h0, "ld_b201_u");       drain();

    preload(32'h200, 32'h11223344);
    issue(1, 1, 2'b01, 0, 32'h202, 32'h00008001, "st_h202"); drain();
    chk("mem_h202", dmem[32'h200 >> 2], 32'h80013344);
    issue(1, 0, 2'b01, 0, 32'h202, 32'h0, "ld_h202_s");
    issue(1, 0, 2'b01, 1, 32'h202, 32'h0, "ld_h202_u");       drain();

    issue(0, 1, 2'b10, 0, 32'hFFC, 32'hCAFEF00D, "st_wtop");
    issue(0, 0, 2'b00, 1, 32'hFFF, 32'h0, "ld_btop");
    issue(0, 0, 2'b10, 0, 32'hFFC, 32'h0, "ld_wtop");         drain();

    mr0 = nmemreq;
    issue(0, 0, 2'b10, 0, 32'h102, 32'h0, "err_w102");
    issue(0, 1, 2'b01, 0, 32'h103, 32'h1234, "err_h103");
    issue(1, 0, 2'b11, 0, 32'h100, 32'h0, "err_sz3");
    issue(0, 0, 2'b00, 0, 32'h1000, 32'h0, "err_b1000");      drain();
    chk("err_no_memreq", nmemreq, mr0);

    preload(32'h300, 32'h55667788);
    mw0 = nmemwe; rv0 = nrvalid;
    bus.we0_i = 1; bus.size0_i = 2'b00; bus.unsigned0_i = 0; bus.addr0_i = 32'h301; bus.wdata0_i = 32'h99;
    bus.req0_i = 1'b1;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = bus.gnt0_o; end
      chk("rmw_rst_granted", got, 1);
    end
    @(posedge clk); #1;
    rst = 1'b1; bus.req0_i = 1'b0;
    begin
      exp_t e;
      predict(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, "ld_after_rst", e);
      q1.push_back(e);
    end
    bus.we1_i = 0; bus.size1_i = 2'b10; bus.unsigned1_i = 0; bus.addr1_i = 32'h300; bus.wdata1_i = 0;
    bus.req1_i = 1'b1;
    @(negedge clk);
    chk("rmw_rst_memreq", bus.mem_req_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("gnt_during_rst", bus.gnt1_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("gnt_first_after_rst", bus.gnt1_o, 1);
    @(posedge clk); #1;
    bus.req1_i = 1'b0;
    drain();
    chk("rmw_rst_no_write", nmemwe, mw0);
    chk("rmw_rst_mem_word", dmem[32'h300 >> 2], 32'h55667788);
    chk("rmw_rst_rvalids", nrvalid - rv0, 1);

    reset_dut();
    preload(32'h400, 32'hA0A0A0A0); preload(32'h404, 32'hB1B1B1B1);
    preload(32'h408, 32'hC2C2C2C2); preload(32'h40C, 32'hD3D3D3D3);
    gnt_log.delete();
    fork
      begin
        issue(0, 0, 2'b10, 0, 32'h400, 32'h0, "arb_p0_a");
        issue(0, 0, 2'b10, 0, 32'h408, 32'h0, "arb_p0_b");
      end
      begin
        issue(1, 0, 2'b10, 0, 32'h404, 32'h0, "arb_p1_a");
        issue(1, 0, 2'b10, 0, 32'h40C, 32'h0, "arb_p1_b");
      end
    join
    drain();
    chk("arb_ngrants", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("arb_grant%0d", i), (i < gnt_log.size()) ? gnt_log[i] : 32'hFFFF_FFFF, i % 2);

    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
